// File: rtl/axi_llc_pkg.sv
// axi_llc_pkg: shared constants and types for the LLC refill path.
//   RefillFifoDepth         - depth of the refill FIFO between AR and R masters.
//   RefillArbMaxOutstanding - credit limit of the refill arbiter; kept at least
//                             RefillFifoDepth + 1 so the refill FIFO never
//                             back-pressures the AR master because of the arbiter.
//   refill_arb_state_e      - refill arbiter FSM states.
package axi_llc_pkg;

  localparam int RefillFifoDepth         = 3;
  localparam int RefillArbMaxOutstanding = 4;

  typedef enum logic {
    ARB_IDLE,
    ARB_OFFER
  } refill_arb_state_e;

endpackage

// File: rtl/axi_llc_credit_cnt.sv
// axi_llc_credit_cnt: saturating up/down credit counter with limit compare.
//   clk_i, rst_i - clock, synchronous active-high reset
//   inc_i        - take one credit (honoured only while avail_o is high)
//   dec_i        - return one credit (ignored when the count is already 0)
//   cnt_o        - credits currently taken
//   avail_o      - a credit can be taken this cycle, counting a same-cycle dec_i
module axi_llc_credit_cnt #(
  parameter  int unsigned MaxCount = 4,
  localparam int unsigned CntW     = $clog2(MaxCount + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            avail_o
);

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_eff;
  logic            dec_eff;

  // A return in the same cycle frees its credit for an immediate re-take.
  always_comb begin
    dec_eff = dec_i && (cnt_q != '0);
    cnt_eff = cnt_q - CntW'(dec_eff);
    avail_o = cnt_eff < CntW'(MaxCount);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_eff + CntW'(inc_i && avail_o);
    end
  end

  assign cnt_o = cnt_q;

  // A return with no credit taken indicates a protocol error upstream.
  assert property (@(posedge clk_i) disable iff (rst_i) !(dec_i && (cnt_q == '0)));

endmodule

// File: rtl/axi_llc_refill_arb.sv
// axi_llc_refill_arb: round-robin arbiter and credit scheduler in front of the
// LLC refill unit.
//   clk_i, rst_i  - clock, synchronous active-high reset
//   stall_i       - suppresses new grants; a pending offer still completes
//   req_desc_i    - per-requester descriptors
//   req_valid_i   - per-requester valid
//   req_ready_o   - one-hot grant, high only in the capture cycle
//   desc_o        - registered winning descriptor
//   desc_valid_o  - desc_o is valid (held until desc_ready_i)
//   desc_ready_i  - refill unit accepts desc_o
//   grant_idx_o   - requester index of desc_o
//   done_i        - one pulse per completed refill
//   outstanding_o - refills captured but not yet completed
//   busy_o        - credits in use or an offer pending
module axi_llc_refill_arb
  import axi_llc_pkg::*;
#(
  parameter  int unsigned NumReq         = 2,
  parameter  int unsigned MaxOutstanding = RefillArbMaxOutstanding,
  parameter  type         desc_t         = logic,
  localparam int unsigned IdxW           = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  desc_t             req_desc_i [NumReq],
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  output desc_t             desc_o,
  output logic              desc_valid_o,
  input  logic              desc_ready_i,
  output logic [IdxW-1:0]   grant_idx_o,
  input  logic              done_i,
  output logic [CntW-1:0]   outstanding_o,
  output logic              busy_o
);

  refill_arb_state_e state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   winner;
  logic [IdxW-1:0]   rr_next;
  logic              found;
  logic              credit_avail;
  logic              capture;
  desc_t             desc_q;
  logic [IdxW-1:0]   grant_q;

  // First valid requester at or after rr_ptr_q, wrapping modulo NumReq.
  always_comb begin
    int unsigned cand;
    cand   = 0;
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(rr_ptr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!found && req_valid_i[IdxW'(cand)]) begin
        found  = 1'b1;
        winner = IdxW'(cand);
      end
    end
    rr_next = (32'(winner) == NumReq - 1) ? '0 : winner + 1'b1;
  end

  // In ARB_IDLE the state term alone enables capture, so desc_ready_i never
  // reaches req_ready_o combinationally there.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    capture     = !rst_i && !stall_i && found && credit_avail &&
                  ((state_q == ARB_IDLE) || desc_ready_i);
    if (capture) begin
      req_ready_o[winner] = 1'b1;
      state_d             = ARB_OFFER;
    end else if ((state_q == ARB_OFFER) && desc_ready_i) begin
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      desc_q   <= '0;
      grant_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        desc_q   <= req_desc_i[winner];
        grant_q  <= winner;
        rr_ptr_q <= rr_next;
      end
    end
  end

  axi_llc_credit_cnt #(
    .MaxCount(MaxOutstanding)
  ) i_credit_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (capture),
    .dec_i  (done_i),
    .cnt_o  (outstanding_o),
    .avail_o(credit_avail)
  );

  assign desc_o       = desc_q;
  assign grant_idx_o  = grant_q;
  assign desc_valid_o = (state_q == ARB_OFFER);
  assign busy_o       = (outstanding_o != '0) || desc_valid_o;

endmodule
